// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter in front of the I/O register slave port.
// One transaction in flight: IDLE -> ACCESS (strobes held ACCESS_CYCLES) -> ACK -> IDLE.
module io_bus_arbiter #(
  parameter int AW            = 11,
  parameter int DW            = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_writedata,
  input  logic [3:0]    m0_be,
  output logic          m0_ack,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_writedata,
  input  logic [3:0]    m1_be,
  output logic          m1_ack,
  output logic [DW-1:0] readdata,
  output logic          s_read,
  output logic          s_write,
  output logic [AW-1:0] s_address,
  output logic [DW-1:0] s_writedata,
  output logic [3:0]    s_be,
  input  logic [DW-1:0] s_readdata,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;
  localparam logic [3:0] CNT_INIT  = 4'(ACCESS_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          last_grant_q, last_grant_d;
  logic          op_write_q, op_write_d;
  logic          s_read_q, s_read_d;
  logic          s_write_q, s_write_d;
  logic [AW-1:0] s_address_q, s_address_d;
  logic [DW-1:0] s_writedata_q, s_writedata_d;
  logic [3:0]    s_be_q, s_be_d;
  logic [DW-1:0] readdata_q, readdata_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;

  logic req0, req1, win1, win_write;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // On contention the master that was not served last wins.
  assign win1      = (req0 && req1) ? ~last_grant_q : req1;
  assign win_write = win1 ? m1_write : m0_write;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    last_grant_d  = last_grant_q;
    op_write_d    = op_write_q;
    s_read_d      = s_read_q;
    s_write_d     = s_write_q;
    s_address_d   = s_address_q;
    s_writedata_d = s_writedata_q;
    s_be_d        = s_be_q;
    readdata_d    = readdata_q;
    m0_ack_d      = 1'b0;
    m1_ack_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d         = win1;
          op_write_d    = win_write;
          s_address_d   = win1 ? m1_address : m0_address;
          s_writedata_d = win1 ? m1_writedata : m0_writedata;
          s_be_d        = win1 ? m1_be : m0_be;
          s_write_d     = win_write;
          s_read_d      = ~win_write;
          cnt_d         = CNT_INIT;
          state_d       = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!op_write_q) begin
            readdata_d = s_readdata;
          end
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          m0_ack_d  = ~gnt_q;
          m1_ack_d  = gnt_q;
          state_d   = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        last_grant_d = gnt_q;
        state_d      = ST_IDLE;
      end
      default: begin
        s_read_d  = 1'b0;
        s_write_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      gnt_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      op_write_q    <= 1'b0;
      s_read_q      <= 1'b0;
      s_write_q     <= 1'b0;
      s_address_q   <= '0;
      s_writedata_q <= '0;
      s_be_q        <= 4'd0;
      readdata_q    <= '0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      last_grant_q  <= last_grant_d;
      op_write_q    <= op_write_d;
      s_read_q      <= s_read_d;
      s_write_q     <= s_write_d;
      s_address_q   <= s_address_d;
      s_writedata_q <= s_writedata_d;
      s_be_q        <= s_be_d;
      readdata_q    <= readdata_d;
      m0_ack_q      <= m0_ack_d;
      m1_ack_q      <= m1_ack_d;
    end
  end

  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign s_read      = s_read_q;
  assign s_write     = s_write_q;
  assign s_address   = s_address_q;
  assign s_writedata = s_writedata_q;
  assign s_be        = s_be_q;
  assign readdata    = readdata_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
